// File: rtl/l0_loader.sv
// Fetch stage that streams consecutive activation vectors from the activation SRAM into L0.
// A 3-entry credit-managed queue absorbs SRAM read latency and L0 back-pressure.
module l0_loader #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [addr_w:0]     num_vec,
  output logic                mem_cen,
  output logic                mem_wen,
  output logic [addr_w-1:0]   mem_addr,
  input  logic [row*bw-1:0]   mem_q,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_wr,
  input  logic                l0_full,
  output logic                busy,
  output logic                done
);

  localparam int dw = row * bw;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic [addr_w-1:0] base_q;
  logic [addr_w:0]   num_q;
  logic [addr_w:0]   issued;
  logic [addr_w:0]   written;
  logic              inflight;
  logic [dw-1:0]     fifo [3];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              issue;

  // Credit counts both queued entries and the read whose data lands next cycle.
  assign issue = (state == FETCH) && (issued < num_q) &&
                 (({1'b0, count} + {2'b00, inflight}) < 3'd3);

  assign l0_wr    = (count != 2'd0) && !l0_full;
  assign l0_in    = (count != 2'd0) ? fifo[rd_ptr] : '0;
  assign mem_cen  = !issue;
  assign mem_wen  = 1'b1;
  assign mem_addr = issue ? base_q + issued[addr_w-1:0] : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = (num_vec == '0) ? DONE : FETCH;
      FETCH: if (issue && (issued + 1'b1 == num_q)) next_state = DRAIN;
      DRAIN: if (l0_wr && (written + 1'b1 == num_q)) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      issued   <= '0;
      written  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= next_state;
      inflight <= issue;
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        num_q   <= num_vec;
        issued  <= '0;
        written <= '0;
      end else begin
        if (issue) issued  <= issued + 1'b1;
        if (l0_wr) written <= written + 1'b1;
      end
      if (inflight) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      if (l0_wr)    rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      unique case ({inflight, l0_wr})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (inflight) fifo[wr_ptr] <= mem_q;
  end

endmodule

// File: tb/tb_l0_loader.sv
// Self-checking bench for l0_loader: a behavioural SRAM plus an address/data/timing reference model.
module tb_l0_loader;

  logic        clk = 1'b0;
  logic        reset, start, l0_full;
  logic [10:0] base_addr, mem_addr;
  logic [11:0] num_vec;
  logic        mem_cen, mem_wen, l0_wr, busy, done;
  logic [31:0] mem_q, l0_in;
  logic [31:0] sram [2048];

  int checks = 0;
  int errors = 0;

  l0_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_q(mem_q),
    .l0_in(l0_in), .l0_wr(l0_wr), .l0_full(l0_full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) if (!mem_cen) mem_q <= sram[mem_addr];

  // mode: 0 no back-pressure, 1 random l0_full, 2 l0_full in cycles 4..12, 3 second start at cycle 5
  function automatic logic full_for(input int mode, input int k);
    if (mode == 1) return ($urandom_range(0, 2) == 0);
    if (mode == 2) return (k >= 4 && k <= 12);
    return 1'b0;
  endfunction

  task automatic run_job(input string name, input int base, input int n, input int mode, input int abort_at);
    int reads = 0;
    int writes = 0;
    int last_wr = -1;
    bit fin = 1'b0;
    logic [10:0] ea;
    logic [31:0] ed;
    @(posedge clk); #1;
    reset = 1'b0;
    base_addr = 11'(base);
    num_vec = 12'(n);
    start = 1'b1;
    l0_full = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (abort_at >= 0 && k == abort_at + 1) begin
        checks++;
        if ({mem_cen, mem_wen, mem_addr, l0_wr, l0_in, busy, done} !== {1'b1, 1'b1, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s reset_outputs: cen=%b wen=%b addr=%0d wr=%b in=%h busy=%b done=%b, want 1 1 0 0 0 0 0",
                   name, mem_cen, mem_wen, mem_addr, l0_wr, l0_in, busy, done);
        end
        return;
      end
      if (fin) begin
        checks++;
        if ({busy, done, mem_cen, l0_wr} !== 4'b0010) begin
          errors++;
          $display("FAIL %s idle_after_done: busy=%b done=%b cen=%b wr=%b, want 0 0 1 0", name, busy, done, mem_cen, l0_wr);
        end
        return;
      end
      checks++;
      if (mem_wen !== 1'b1) begin
        errors++;
        $display("FAIL %s mem_wen cycle %0d: got %b want 1", name, k, mem_wen);
      end
      if (mem_cen === 1'b0) begin
        ea = 11'((base + reads) % 2048);
        checks++;
        if (mem_addr !== ea || reads >= n) begin
          errors++;
          $display("FAIL %s read_addr cycle %0d: got %0d want %0d (read %0d of %0d)", name, k, mem_addr, ea, reads, n);
        end
        reads++;
      end
      if (l0_wr === 1'b1) begin
        ed = sram[(base + writes) % 2048];
        checks++;
        if (l0_full !== 1'b0 || l0_in !== ed || writes >= n) begin
          errors++;
          $display("FAIL %s l0_write cycle %0d: data %h full %b want data %h full 0 (write %0d of %0d)",
                   name, k, l0_in, l0_full, ed, writes, n);
        end
        writes++;
        last_wr = k;
      end
      checks++;
      if (reads - writes > 3) begin
        errors++;
        $display("FAIL %s queue_bound cycle %0d: outstanding %0d want <= 3", name, k, reads - writes);
      end
      if (mode == 0 || mode == 3) begin
        checks++;
        if ({~mem_cen, l0_wr, done} !== {k >= 1 && k <= n, k >= 3 && k <= n + 2, (n == 0) ? k == 1 : k == n + 3}) begin
          errors++;
          $display("FAIL %s timing cycle %0d: read=%b wr=%b done=%b want %b %b %b", name, k, ~mem_cen, l0_wr, done,
                   k >= 1 && k <= n, k >= 3 && k <= n + 2, (n == 0) ? k == 1 : k == n + 3);
        end
      end
      checks++;
      if (busy !== (k >= 1)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, k >= 1);
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (reads != n || writes != n || ((n == 0) ? k != 1 : k != last_wr + 1)) begin
          errors++;
          $display("FAIL %s done cycle %0d: reads %0d writes %0d last_write %0d want %0d %0d and done one cycle after",
                   name, k, reads, writes, last_wr, n, n);
        end
      end
      @(posedge clk); #1;
      start = (mode == 3 && k + 1 == 5);
      if (start) begin
        base_addr = 11'(base + 100);
        num_vec = 12'd7;
      end
      reset = (abort_at >= 0 && k + 1 == abort_at);
      l0_full = full_for(mode, k + 1);
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: no done after 3000 cycles, got %0d writes want %0d", name, writes, n);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; l0_full = 1'b0; base_addr = '0; num_vec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_cen, mem_wen, mem_addr, l0_wr, l0_in, busy, done} !== {1'b1, 1'b1, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: cen=%b wen=%b addr=%0d wr=%b in=%h busy=%b done=%b, want 1 1 0 0 0 0 0",
               mem_cen, mem_wen, mem_addr, l0_wr, l0_in, busy, done);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) sram[i] = 32'(32'h1111_1111 * (i + 1));
    run_job("basic", 0, 4, 0, -1);
  endtask

  task automatic test_back_pressure();
    run_job("back_pressure", 300, 16, 2, -1);
  endtask

  task automatic test_wrap();
    run_job("wrap", 2046, 4, 0, -1);
  endtask

  task automatic test_zero_length();
    run_job("zero_length", 77, 0, 0, -1);
  endtask

  task automatic test_reset_mid_run();
    run_job("reset_mid_run", 500, 32, 0, 10);
    run_job("after_reset", 900, 2, 0, -1);
  endtask

  task automatic test_start_while_busy();
    run_job("start_while_busy", 1200, 12, 3, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++)
      run_job("random", int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)), 1, -1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) sram[i] = $urandom;
    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap();
    test_zero_length();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back: for (int j = 0; j < 2; j++) run_job("back_to_back", 40 * j, 5, 0, -1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l0_loader.md
# l0_loader

Upstream fetch stage for the L0 input FIFO bank. On `start`, it streams `num_vec` consecutive activation vectors (`row*bw` bits each) from the single-port activation SRAM into L0. It honours L0 back-pressure through a 3-entry internal queue, so no SRAM read data is ever lost or duplicated. It pulses `done` once the last vector has been written into L0.

## Interface
- `row`, 8, number of L0 rows (vector lanes)
- `bw`, 4, bits per lane
- `addr_w`, 11, SRAM address width
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  addr_w  first SRAM address; latched on accepted `start`
- `num_vec`  in  addr_w+1  vector count; latched on accepted `start`
- `mem_cen`  out  1  SRAM chip enable, active-low
- `mem_wen`  out  1  SRAM write enable, active-low; tied 1
- `mem_addr`  out  addr_w  SRAM read address
- `mem_q`  in  row*bw  SRAM read data, valid the cycle after `mem_cen`=0
- `l0_in`  out  row*bw  vector to L0
- `l0_wr`  out  1  L0 write strobe
- `l0_full`  in  1  L0 cannot accept a write this cycle
- `busy`  out  1  high in FETCH/DRAIN/DONE
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE
  - `start`=1 latches `base_addr`/`num_vec` and clears the counters `issued` and `written` (both addr_w+1 bits).
  - If `num_vec`==0, go to DONE; otherwise go to FETCH.
  - `start` is ignored in every other state.
- FETCH
  - Issue a read in a cycle only when `issued` < `num_vec` and `occ + inflight` < 3.
    - `occ` is the queue occupancy at the start of the cycle.
    - `inflight` = a read was issued in the previous cycle.
  - On issue: `mem_cen`=0, `mem_addr` = (`base_addr` + `issued`) mod 2^addr_w (address wrap is legal), and `issued` increments.
  - Move to DRAIN the cycle after `issued` reaches `num_vec`.
- Return path: `mem_q` is pushed into the queue on the cycle after each issue. The credit rule guarantees the queue never overflows.
- L0 write path
  - `l0_wr` = queue non-empty AND !`l0_full`. This is combinational on `l0_full`.
  - `l0_in` = queue head; the head pops when `l0_wr`=1.
  - `written` increments on every `l0_wr`.
  - `l0_wr` is never asserted while `l0_full`=1.
- DRAIN: no reads are issued. Go to DONE in the cycle after `written`==`num_vec` is reached.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Order: vectors reach L0 in ascending address order, exactly once each.
- Reset (including mid-operation)
  - Next state is IDLE, the queue and counters are cleared, and the in-flight return is discarded.
  - After reset: `mem_cen`=1, `mem_wen`=1, `mem_addr`=0, `l0_wr`=0, `l0_in`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at cycle 0.
  - First `mem_cen`=0 at cycle 1.
  - `mem_q` valid at cycle 2, queued at the end of cycle 2.
  - First `l0_wr` at cycle 3, giving start-to-first-write latency 3.
- No back-pressure, N≥1
  - Reads at cycles 1..N and writes at cycles 3..N+2, one per cycle.
  - `done` at cycle N+3; `busy` high for cycles 1..N+3.
- `num_vec`=0: `done` and `busy` are high at cycle 1, with no SRAM or L0 activity.
- `l0_full` rising at cycle t
  - `l0_wr`=0 from cycle t.
  - At most 3 vectors are held in the queue; reads stop once `occ + inflight` = 3.
- `l0_full` falling at cycle t: `l0_wr`=1 at cycle t if the queue is non-empty, and reads resume as credit frees.
- Steady-state throughput is 1 vector/cycle; the 3-entry queue exists for exactly this.

## Test plan
- Basic stream: `base_addr`=0, `num_vec`=4, SRAM[i]=32'h1111_1111*(i+1), `l0_full`=0 → `l0_wr` at cycles 3–6 carrying those values in order; `done` at cycle 7.
- Back-pressure: `num_vec`=16, `l0_full`=1 for cycles 4–12 → no `l0_wr` in 4–12; at most 3 queued; all 16 vectors arrive in order with no duplicates; `done` one cycle after the 16th write.
- Address wrap: `addr_w`=11, `base_addr`=2046, `num_vec`=4 → `mem_addr` sequence 2046, 2047, 0, 1.
- Zero length: `num_vec`=0 → `done` at cycle 1; `mem_cen` stays 1 and `l0_wr` stays 0.
- Reset mid-run: `num_vec`=32, `reset` at cycle 10 → at cycle 11 all outputs are at reset values; a new `start` with `num_vec`=2 completes normally with only the new data written.
- Start while busy: second `start` during FETCH → ignored; exactly `num_vec` writes from the first request.
